// File: rtl/axis_pkt_rr_arbiter_if.sv
// Bundle of the multi-port AXI-Stream request side and the single shared
// output stream of the packet round-robin arbiter.
// "slave" is the arbiter's view (it consumes the per-port requests),
// "master" is the view of whoever drives the requesters and the sink ready.
interface axis_pkt_rr_arbiter_if #(
  parameter int NUM_PORTS        = 4,
  parameter int AXIS_TDATA_WIDTH = 64,
  parameter int AXIS_TDEST_WIDTH = 4,
  parameter int AXIS_TID_WIDTH   = 4,
  parameter int AXIS_TUSER_WIDTH = 4,
  parameter int AXIS_TKEEP_WIDTH = AXIS_TDATA_WIDTH / 8,
  parameter int AXIS_TSTRB_WIDTH = AXIS_TDATA_WIDTH / 8
);

  // per-port request side, port p occupies slice p
  logic [NUM_PORTS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS*AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep;
  logic [NUM_PORTS*AXIS_TSTRB_WIDTH-1:0] s_axis_tstrb;
  logic [NUM_PORTS*AXIS_TDEST_WIDTH-1:0] s_axis_tdest;
  logic [NUM_PORTS*AXIS_TUSER_WIDTH-1:0] s_axis_tuser;
  logic [NUM_PORTS-1:0]                  s_axis_tvalid;
  logic [NUM_PORTS-1:0]                  s_axis_tlast;
  logic [NUM_PORTS-1:0]                  s_axis_tready;

  // shared output towards the stream FIFO
  logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata;
  logic [AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep;
  logic [AXIS_TSTRB_WIDTH-1:0] m_axis_tstrb;
  logic [AXIS_TDEST_WIDTH-1:0] m_axis_tdest;
  logic [AXIS_TUSER_WIDTH-1:0] m_axis_tuser;
  logic [AXIS_TID_WIDTH-1:0]   m_axis_tid;
  logic                        m_axis_tvalid;
  logic                        m_axis_tlast;
  logic                        m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tstrb, s_axis_tdest, s_axis_tuser,
    input  s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tdest, m_axis_tuser,
    output m_axis_tid, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tstrb, s_axis_tdest, s_axis_tuser,
    output s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tdest, m_axis_tuser,
    input  m_axis_tid, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );

endinterface

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-level round-robin arbiter: NUM_PORTS AXI-Stream requesters share one
// sink. A grant is held from the first beat to the accepted tlast beat, the
// granted index is stamped onto tid, and a two-entry skid stage (main +
// overflow) decouples the arbiter from the sink's ready.
module axis_pkt_rr_arbiter #(
  parameter int NUM_PORTS        = 4,
  parameter int AXIS_TDATA_WIDTH = 64,
  parameter int AXIS_TDEST_WIDTH = 4,
  parameter int AXIS_TID_WIDTH   = 4,
  parameter int AXIS_TUSER_WIDTH = 4,
  parameter int AXIS_TKEEP_WIDTH = AXIS_TDATA_WIDTH / 8,
  parameter int AXIS_TSTRB_WIDTH = AXIS_TDATA_WIDTH / 8
) (
  input  logic                          s_axis_clk,
  input  logic                          s_axis_rst_n,
  axis_pkt_rr_arbiter_if.slave          bus,
  output logic                          grant_active,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_idx
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int DW    = AXIS_TDATA_WIDTH;
  localparam int KW    = AXIS_TKEEP_WIDTH;
  localparam int SW    = AXIS_TSTRB_WIDTH;
  localparam int DSTW  = AXIS_TDEST_WIDTH;
  localparam int UW    = AXIS_TUSER_WIDTH;
  localparam int TIDW  = AXIS_TID_WIDTH;

  // parameter sanity: the port index must fit in tid, and 2..16 ports
  if (AXIS_TID_WIDTH < $clog2(NUM_PORTS)) begin : g_tid_width_check
    $error("axis_pkt_rr_arbiter: AXIS_TID_WIDTH too narrow for NUM_PORTS");
  end
  if ((NUM_PORTS < 2) || (NUM_PORTS > 16)) begin : g_num_ports_check
    $error("axis_pkt_rr_arbiter: NUM_PORTS must be within 2..16");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // one stored beat of the skid stage, tid already stamped
  typedef struct packed {
    logic [DW-1:0]   data;
    logic [KW-1:0]   keep;
    logic [SW-1:0]   strb;
    logic [DSTW-1:0] dest;
    logic [UW-1:0]   user;
    logic [TIDW-1:0] tid;
    logic            last;
  } beat_t;

  // wrap-around increment of a port index (NUM_PORTS-1 goes back to 0)
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(NUM_PORTS - 1)) ? {IDX_W{1'b0}} : (v + IDX_W'(1));
  endfunction

  state_t           state_r;
  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] grant_idx_r;

  beat_t main_r;
  logic  main_valid_r;
  beat_t ovf_r;
  logic  ovf_valid_r;

  // per-port payload slices
  logic [DW-1:0]   port_data_s [NUM_PORTS];
  logic [KW-1:0]   port_keep_s [NUM_PORTS];
  logic [SW-1:0]   port_strb_s [NUM_PORTS];
  logic [DSTW-1:0] port_dest_s [NUM_PORTS];
  logic [UW-1:0]   port_user_s [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign port_data_s[p] = bus.s_axis_tdata[p*DW +: DW];
    assign port_keep_s[p] = bus.s_axis_tkeep[p*KW +: KW];
    assign port_strb_s[p] = bus.s_axis_tstrb[p*SW +: SW];
    assign port_dest_s[p] = bus.s_axis_tdest[p*DSTW +: DSTW];
    assign port_user_s[p] = bus.s_axis_tuser[p*UW +: UW];
  end

  logic             pick_found_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic [IDX_W-1:0] cand_s;
  logic             skid_ready_s;
  logic             accept_s;
  logic             pop_s;
  beat_t            in_beat_s;

  // round-robin scan: first requesting port starting at rr_ptr
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = rr_ptr_r;
    cand_s       = rr_ptr_r;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pick_idx_s   = (!pick_found_s && bus.s_axis_tvalid[cand_s]) ? cand_s : pick_idx_s;
      pick_found_s = pick_found_s | bus.s_axis_tvalid[cand_s];
      cand_s       = next_idx(cand_s);
    end
  end

  // handshakes and the beat as it will be stored
  always_comb begin
    skid_ready_s   = (state_r == BUSY) && !ovf_valid_r;
    accept_s       = skid_ready_s && bus.s_axis_tvalid[grant_idx_r];
    pop_s          = main_valid_r && bus.m_axis_tready;
    in_beat_s.data = port_data_s[grant_idx_r];
    in_beat_s.keep = port_keep_s[grant_idx_r];
    in_beat_s.strb = port_strb_s[grant_idx_r];
    in_beat_s.dest = port_dest_s[grant_idx_r];
    in_beat_s.user = port_user_s[grant_idx_r];
    in_beat_s.tid  = TIDW'(grant_idx_r);
    in_beat_s.last = bus.s_axis_tlast[grant_idx_r];
  end

  // only the granted port sees ready, and only while overflow is free
  assign bus.s_axis_tready = skid_ready_s
                           ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_idx_r)
                           : {NUM_PORTS{1'b0}};

  assign grant_active = (state_r == BUSY);
  assign grant_idx    = grant_idx_r;

  assign bus.m_axis_tdata  = main_r.data;
  assign bus.m_axis_tkeep  = main_r.keep;
  assign bus.m_axis_tstrb  = main_r.strb;
  assign bus.m_axis_tdest  = main_r.dest;
  assign bus.m_axis_tuser  = main_r.user;
  assign bus.m_axis_tid    = main_r.tid;
  assign bus.m_axis_tlast  = main_r.last;
  assign bus.m_axis_tvalid = main_valid_r;

  // arbitration FSM: grant in IDLE, hold until the tlast beat is accepted
  always_ff @(posedge s_axis_clk or negedge s_axis_rst_n) begin
    if (!s_axis_rst_n) begin
      state_r     <= IDLE;
      rr_ptr_r    <= {IDX_W{1'b0}};
      grant_idx_r <= {IDX_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            grant_idx_r <= pick_idx_s;
            state_r     <= BUSY;
          end
        end
        BUSY: begin
          if (accept_s && in_beat_s.last) begin
            rr_ptr_r <= next_idx(grant_idx_r);
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // skid stage: main holds the presented beat, overflow catches one extra
  always_ff @(posedge s_axis_clk or negedge s_axis_rst_n) begin
    if (!s_axis_rst_n) begin
      main_r       <= '0;
      main_valid_r <= 1'b0;
      ovf_r        <= '0;
      ovf_valid_r  <= 1'b0;
    end else begin
      if (pop_s) begin
        if (ovf_valid_r) begin
          main_r      <= ovf_r;
          ovf_valid_r <= 1'b0;
        end else if (accept_s) begin
          main_r <= in_beat_s;
        end else begin
          main_valid_r <= 1'b0;
        end
      end else if (!main_valid_r) begin
        if (accept_s) begin
          main_r       <= in_beat_s;
          main_valid_r <= 1'b1;
        end
      end else if (accept_s) begin
        ovf_r       <= in_beat_s;
        ovf_valid_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Randomized bench for axis_pkt_rr_arbiter: a cycle-level reference model
// (rotating priority, 2-beat buffer capacity) predicts ready/grant and
// pushes expected beats to a scoreboard drained by an output monitor.
module tb_axis_pkt_rr_arbiter;

  localparam int NP    = 4;
  localparam int DW    = 64;
  localparam int DSTW  = 4;
  localparam int TIDW  = 4;
  localparam int UW    = 4;
  localparam int KW    = DW / 8;
  localparam int SW    = DW / 8;
  localparam int IW    = $clog2(NP);

  typedef struct {
    logic [DW-1:0]   data;
    logic [KW-1:0]   keep;
    logic [SW-1:0]   strb;
    logic [DSTW-1:0] dest;
    logic [UW-1:0]   user;
    logic [TIDW-1:0] tid;
    logic            last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic grant_active;
  logic [IW-1:0] grant_idx;

  always #5 clk = ~clk;

  axis_pkt_rr_arbiter_if #(
    .NUM_PORTS(NP), .AXIS_TDATA_WIDTH(DW), .AXIS_TDEST_WIDTH(DSTW),
    .AXIS_TID_WIDTH(TIDW), .AXIS_TUSER_WIDTH(UW),
    .AXIS_TKEEP_WIDTH(KW), .AXIS_TSTRB_WIDTH(SW)
  ) bus ();

  axis_pkt_rr_arbiter #(
    .NUM_PORTS(NP), .AXIS_TDATA_WIDTH(DW), .AXIS_TDEST_WIDTH(DSTW),
    .AXIS_TID_WIDTH(TIDW), .AXIS_TUSER_WIDTH(UW),
    .AXIS_TKEEP_WIDTH(KW), .AXIS_TSTRB_WIDTH(SW)
  ) dut (
    .s_axis_clk  (clk),
    .s_axis_rst_n(rst_n),
    .bus         (bus),
    .grant_active(grant_active),
    .grant_idx   (grant_idx)
  );

  int total = 0;
  int bad   = 0;

  // stimulus state per port
  logic [DW-1:0]   p_data [NP];
  logic [KW-1:0]   p_keep [NP];
  logic [SW-1:0]   p_strb [NP];
  logic [DSTW-1:0] p_dest [NP];
  logic [UW-1:0]   p_user [NP];
  logic            p_valid[NP];
  logic            p_last [NP];
  int              rem    [NP];
  logic [NP-1:0]   acc_vec = '0;
  int              vprob = 0, mt_prob = 100, fixed_len = 0, max_len = 5;
  logic [NP-1:0]   en_mask = '1;

  // reference model
  beat_t exp_q[$];
  bit    mdl_busy = 1'b0;
  int    mdl_grant = 0, mdl_ptr = 0, mdl_held = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (acc_vec[p]) begin
        rem[p]--;
        p_valid[p] = 1'b0;
      end
      if (!p_valid[p]) begin
        p_data[p] = {$urandom, $urandom};
        p_keep[p] = KW'($urandom);
        p_strb[p] = SW'($urandom);
        p_dest[p] = DSTW'($urandom);
        p_user[p] = UW'($urandom);
        p_last[p] = 1'($urandom);
        if (en_mask[p] && ($urandom_range(99) < vprob)) begin
          if (rem[p] <= 0) rem[p] = (fixed_len > 0) ? fixed_len : $urandom_range(max_len, 1);
          p_valid[p] = 1'b1;
          p_last[p]  = (rem[p] == 1);
        end
      end
      bus.s_axis_tdata[p*DW +: DW]     = p_data[p];
      bus.s_axis_tkeep[p*KW +: KW]     = p_keep[p];
      bus.s_axis_tstrb[p*SW +: SW]     = p_strb[p];
      bus.s_axis_tdest[p*DSTW +: DSTW] = p_dest[p];
      bus.s_axis_tuser[p*UW +: UW]     = p_user[p];
      bus.s_axis_tvalid[p]             = p_valid[p];
      bus.s_axis_tlast[p]              = p_last[p];
    end
    bus.m_axis_tready = ($urandom_range(99) < mt_prob);
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      drive();
    end
  endtask

  task automatic clear_ports();
    for (int p = 0; p < NP; p++) begin
      p_valid[p] = 1'b0;
      rem[p]     = 0;
    end
  endtask

  // reference model: expected ready/valid/grant now, then advance one edge
  always @(negedge clk) begin
    int   pick;
    bit   take, pop;
    beat_t b;
    if (!rst_n) begin
      mdl_busy = 1'b0; mdl_grant = 0; mdl_ptr = 0; mdl_held = 0;
      exp_q.delete();
      acc_vec = '0;
      check("rst_s_tready", 128'(bus.s_axis_tready), 128'(0));
      check("rst_m_tvalid", 128'(bus.m_axis_tvalid), 128'(0));
      check("rst_grant",    128'({grant_active, grant_idx}), 128'(0));
    end else begin
      check("s_tready", 128'(bus.s_axis_tready),
            128'((mdl_busy && mdl_held < 2) ? (1 << mdl_grant) : 0));
      check("m_tvalid", 128'(bus.m_axis_tvalid), 128'(mdl_held > 0));
      check("grant_active", 128'(grant_active), 128'(mdl_busy));
      check("grant_idx", 128'(grant_idx), 128'(mdl_grant));
      acc_vec = bus.s_axis_tvalid & bus.s_axis_tready;
      take = mdl_busy && (mdl_held < 2) && bus.s_axis_tvalid[mdl_grant];
      pop  = (mdl_held > 0) && bus.m_axis_tready;
      if (take) begin
        b.data = p_data[mdl_grant]; b.keep = p_keep[mdl_grant];
        b.strb = p_strb[mdl_grant]; b.dest = p_dest[mdl_grant];
        b.user = p_user[mdl_grant]; b.last = p_last[mdl_grant];
        b.tid  = TIDW'(mdl_grant);
        exp_q.push_back(b);
      end
      mdl_held = mdl_held + int'(take) - int'(pop);
      if (!mdl_busy) begin
        pick = -1;
        for (int k = NP - 1; k >= 0; k--)
          if (bus.s_axis_tvalid[(mdl_ptr + k) % NP]) pick = (mdl_ptr + k) % NP;
        if (pick >= 0) begin
          mdl_grant = pick;
          mdl_busy  = 1'b1;
        end
      end else if (take && p_last[mdl_grant]) begin
        mdl_busy = 1'b0;
        mdl_ptr  = (mdl_grant + 1) % NP;
      end
    end
  end

  // output monitor: pops the scoreboard on each output handshake
  logic  prev_stall = 1'b0;
  beat_t prev_beat;
  always @(negedge clk) begin
    beat_t e, a;
    a.data = bus.m_axis_tdata; a.keep = bus.m_axis_tkeep; a.strb = bus.m_axis_tstrb;
    a.dest = bus.m_axis_tdest; a.user = bus.m_axis_tuser; a.tid = bus.m_axis_tid;
    a.last = bus.m_axis_tlast;
    if (rst_n) begin
      if (prev_stall)
        check("out_stable",
              {35'd0, bus.m_axis_tvalid, a.data, a.keep, a.strb, a.dest, a.user, a.tid, a.last},
              {35'd0, 1'b1, prev_beat.data, prev_beat.keep, prev_beat.strb, prev_beat.dest,
               prev_beat.user, prev_beat.tid, prev_beat.last});
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("out_tid", 128'(a.tid), 128'(e.tid));
          check("out_beat", {36'd0, a.data, a.keep, a.strb, a.dest, a.user, a.last},
                            {36'd0, e.data, e.keep, e.strb, e.dest, e.user, e.last});
        end
      end
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_beat  = a;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    rst_n = 1'b1;
    clear_ports();
    drive();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drive();

    // fairness: everyone streams 3-beat packets, sink always ready
    vprob = 100; fixed_len = 3; mt_prob = 100;
    run(60);
    // random traffic with mid-packet gaps and sink backpressure
    fixed_len = 0; max_len = 6; vprob = 60; mt_prob = 60;
    run(1500);
    // heavy backpressure with long packets
    vprob = 90; max_len = 10; mt_prob = 30;
    run(600);
    // lone port 2 sending single-beat packets
    en_mask = 4'b0100; fixed_len = 1; vprob = 100; mt_prob = 100;
    run(40);
    // pointer wrap: port 3 alone, then port 0 alone
    en_mask = 4'b1000; fixed_len = 2;
    run(20);
    en_mask = 4'b0001;
    run(20);
    // reset in the middle of long packets
    en_mask = '1; fixed_len = 6; vprob = 100; mt_prob = 70;
    run(13);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_s_tready", 128'(bus.s_axis_tready), 128'(0));
    check("async_rst_m_tvalid", 128'({bus.m_axis_tvalid, bus.m_axis_tlast}), 128'(0));
    check("async_rst_m_data", 128'({bus.m_axis_tdata, bus.m_axis_tid}), 128'(0));
    check("async_rst_grant", 128'(grant_active), 128'(0));
    clear_ports();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    en_mask = 4'b1010;
    drive();
    run(30);
    en_mask = '1; fixed_len = 0; max_len = 5; vprob = 70; mt_prob = 50;
    run(800);

    // drain: no new beats, sink ready, bounded wait for the scoreboard
    vprob = 0; mt_prob = 100;
    for (int c = 0; c < 200 && (exp_q.size() != 0 || mdl_held != 0); c++) run(1);
    check("drain_empty", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
